// File: rtl/posit_decode.sv
// rtl/posit_decode.sv - multi-cycle posit<32,3> field decoder
//
// Decodes one posit word into sign, regime value k, exponent and a
// left-aligned mantissa. The regime run is scanned one bit per cycle.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   decode request, sampled only while idle
//   posit_in     in   posit word, captured with start
//   sign_out     out  posit sign bit
//   k_out        out  regime value, two's complement (-30..+30)
//   exp_out      out  exponent field, zero-padded when truncated
//   mantissa_out out  hidden bit at [31], fraction MSB-first below it
//   frac_bits    out  number of fraction bits present in the word
//   is_zero      out  word was 0x00000000
//   is_nar       out  word was 0x80000000
//   busy         out  decoder is not idle
//   done         out  one-cycle result-valid pulse
module posit_decode #(
    parameter int N  = 32,
    parameter int ES = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [N-1:0]  posit_in,
    output logic          sign_out,
    output logic [5:0]    k_out,
    output logic [ES-1:0] exp_out,
    output logic [N-1:0]  mantissa_out,
    output logic [5:0]    frac_bits,
    output logic          is_zero,
    output logic          is_nar,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_EXTRACT,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [N-1:0]   r_word;
    logic [N-1:0]   r_body;
    logic           r_sign;
    logic           r_r0;
    logic [5:0]     r_m;
    logic [4:0]     r_idx;
    logic           r_term;

    logic [N-1:0]   w_body;
    logic           w_special;
    logic           w_bit;
    logic           w_scan_exit;
    logic [5:0]     w_amt;
    logic [N-1:0]   w_tail;

    // Negative posits are decoded from their two's complement.
    assign w_body      = r_word[N-1] ? (~r_word + 1'b1) : r_word;
    assign w_special   = (r_word[N-2:0] == '0);
    assign w_bit       = r_body[r_idx];
    assign w_scan_exit = (w_bit != r_r0) || (r_idx == 5'd0);

    // Bits below the terminator shifted up to the MSB; with no terminator
    // the regime consumed the whole word and nothing remains.
    assign w_amt  = 6'd32 - {1'b0, r_idx};
    assign w_tail = r_term ? (r_body << w_amt) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_LOAD;
            S_LOAD:    w_next = w_special ? S_DONE : S_SCAN;
            S_SCAN:    if (w_scan_exit) w_next = S_EXTRACT;
            S_EXTRACT: w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word       <= '0;
            r_body       <= '0;
            r_sign       <= 1'b0;
            r_r0         <= 1'b0;
            r_m          <= '0;
            r_idx        <= '0;
            r_term       <= 1'b0;
            sign_out     <= 1'b0;
            k_out        <= '0;
            exp_out      <= '0;
            mantissa_out <= '0;
            frac_bits    <= '0;
            is_zero      <= 1'b0;
            is_nar       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            busy <= (w_next != S_IDLE);
            // The pulse appears in the cycle after the DONE state.
            done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) r_word <= posit_in;
                end
                S_LOAD: begin
                    r_sign <= r_word[N-1];
                    r_body <= w_body;
                    r_r0   <= w_body[N-2];
                    r_m    <= '0;
                    r_idx  <= 5'd30;
                    r_term <= 1'b0;
                    if (w_special) begin
                        sign_out     <= r_word[N-1];
                        k_out        <= '0;
                        exp_out      <= '0;
                        mantissa_out <= '0;
                        frac_bits    <= '0;
                        is_zero      <= ~r_word[N-1];
                        is_nar       <= r_word[N-1];
                    end
                end
                S_SCAN: begin
                    if (w_bit == r_r0) begin
                        r_m <= r_m + 6'd1;
                        if (r_idx != 5'd0) r_idx <= r_idx - 5'd1;
                    end else begin
                        r_term <= 1'b1;
                    end
                end
                S_EXTRACT: begin
                    sign_out     <= r_sign;
                    k_out        <= r_r0 ? (r_m - 6'd1) : (6'd0 - r_m);
                    exp_out      <= w_tail[N-1 -: ES];
                    mantissa_out <= {1'b1, w_tail[N-ES-1:0], 2'b00};
                    frac_bits    <= (r_term && r_idx >= 5'(ES))
                                    ? ({1'b0, r_idx} - 6'(ES)) : 6'd0;
                    is_zero      <= 1'b0;
                    is_nar       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_posit_decode.sv
// tb/tb_posit_decode.sv - directed and reference-model bench for posit_decode
module tb_posit_decode;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] posit_in;
    logic        sign_out;
    logic [5:0]  k_out;
    logic [2:0]  exp_out;
    logic [31:0] mantissa_out;
    logic [5:0]  frac_bits;
    logic        is_zero;
    logic        is_nar;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    posit_decode #(.N(32), .ES(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .posit_in     (posit_in),
        .sign_out     (sign_out),
        .k_out        (k_out),
        .exp_out      (exp_out),
        .mantissa_out (mantissa_out),
        .frac_bits    (frac_bits),
        .is_zero      (is_zero),
        .is_nar       (is_nar),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference decoder; sc is the scan length S.
    task automatic ref_decode(input logic [31:0] w, output logic s, output logic [5:0] k,
                              output logic [2:0] e, output logic [31:0] mant,
                              output logic [5:0] fb, output int sc);
        logic [31:0] body;
        logic        r0;
        int          m;
        int          term;
        int          pos;
        s    = w[31];
        body = w[31] ? (~w + 32'd1) : w;
        r0   = body[30];
        m    = 0;
        term = -1;
        for (int i = 30; i >= 0; i--) begin
            if (body[i] == r0) m++;
            else begin
                term = i;
                break;
            end
        end
        k  = r0 ? 6'(m - 1) : 6'(-m);
        sc = (term >= 0) ? m + 1 : 31;
        e  = 3'b000;
        for (int j = 0; j < 3; j++) begin
            pos = term - 1 - j;
            if (term >= 0 && pos >= 0) e[2 - j] = body[pos];
        end
        mant = 32'h8000_0000;
        for (int p = term - 4; p >= 0; p--) mant[30 - (term - 4 - p)] = body[p];
        fb = (term >= 3) ? 6'(term - 3) : 6'd0;
    endtask

    // Issues one decode and returns the edge count at which done appeared.
    // With glitch set, a second start is pulsed while the scan is running.
    task automatic do_decode(input logic [31:0] w, input bit glitch, output int lat);
        @(negedge clk);
        posit_in = w;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        posit_in = $urandom;
        lat      = -1;
        for (int n = 1; n <= 60; n++) begin
            if (glitch && n == 4) begin
                start    = 1'b1;
                posit_in = 32'h4000_0000;
            end
            @(posedge clk);
            #1;
            if (glitch && n == 4) start = 1'b0;
            if (n == 1) check("busy_after_load", {31'd0, busy}, 32'd1);
            if (done) begin
                lat = n;
                break;
            end
        end
        check("busy_at_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic expect_result(input string tag, input int lat, input int exp_lat,
                                 input logic s, input logic [5:0] k, input logic [2:0] e,
                                 input logic [31:0] mant, input logic [5:0] fb,
                                 input logic z, input logic nar);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_sign"}, {31'd0, sign_out}, {31'd0, s});
        check({tag, "_k"}, {26'd0, k_out}, {26'd0, k});
        check({tag, "_exp"}, {29'd0, exp_out}, {29'd0, e});
        check({tag, "_mant"}, mantissa_out, mant);
        check({tag, "_frac"}, {26'd0, frac_bits}, {26'd0, fb});
        check({tag, "_zero"}, {31'd0, is_zero}, {31'd0, z});
        check({tag, "_nar"}, {31'd0, is_nar}, {31'd0, nar});
        @(posedge clk);
        #1;
        check({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] w;
        int          lat;
        logic        s;
        logic [5:0]  k;
        logic [2:0]  e;
        logic [31:0] mant;
        logic [5:0]  fb;
        logic        z;
        logic        nar;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          lat;
        logic        rs;
        logic [5:0]  rk;
        logic [2:0]  re;
        logic [31:0] rm;
        logic [5:0]  rf;
        int          rsc;
        logic [31:0] w;

        vecs[0] = '{32'h4000_0000, 5,  1'b0, 6'd0,  3'd0, 32'h8000_0000, 6'd26, 1'b0, 1'b0};
        vecs[1] = '{32'h4840_0000, 5,  1'b0, 6'd0,  3'd2, 32'h8800_0000, 6'd26, 1'b0, 1'b0};
        vecs[2] = '{32'hC000_0000, 5,  1'b1, 6'd0,  3'd0, 32'h8000_0000, 6'd26, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0001, 34, 1'b0, 6'h22, 3'd0, 32'h8000_0000, 6'd0,  1'b0, 1'b0};
        vecs[4] = '{32'h7FFF_FFFF, 34, 1'b0, 6'd30, 3'd0, 32'h8000_0000, 6'd0,  1'b0, 1'b0};
        vecs[5] = '{32'h0000_0000, 2,  1'b0, 6'd0,  3'd0, 32'h0000_0000, 6'd0,  1'b1, 1'b0};
        vecs[6] = '{32'h8000_0000, 2,  1'b1, 6'd0,  3'd0, 32'h0000_0000, 6'd0,  1'b0, 1'b1};

        rst_n    = 1'b0;
        start    = 1'b0;
        posit_in = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_mant", mantissa_out, 32'd0);
        check("rst_k", {26'd0, k_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            do_decode(vecs[i].w, 1'b0, lat);
            expect_result($sformatf("vec%0d", i), lat, vecs[i].lat, vecs[i].s, vecs[i].k,
                          vecs[i].e, vecs[i].mant, vecs[i].fb, vecs[i].z, vecs[i].nar);
        end

        // Start pulsed mid-scan must not alter the running decode or retrigger.
        do_decode(32'h0000_0001, 1'b1, lat);
        expect_result("glitch", lat, 34, 1'b0, 6'h22, 3'd0, 32'h8000_0000, 6'd0, 1'b0, 1'b0);
        check("glitch_no_retrigger", {31'd0, busy}, 32'd0);

        // Reset in the middle of a scan clears everything at once.
        @(negedge clk);
        posit_in = 32'h7FFF_FFFF;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_mant", mantissa_out, 32'd0);
        check("midrst_frac", {26'd0, frac_bits}, 32'd0);
        check("midrst_sign", {31'd0, sign_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_decode(32'h4840_0000, 1'b0, lat);
        expect_result("postrst", lat, 5, 1'b0, 6'd0, 3'd2, 32'h8800_0000, 6'd26, 1'b0, 1'b0);

        // Random non-special words against the reference decoder.
        for (int t = 0; t < 24; t++) begin
            w = $urandom;
            if (w[30:0] == 31'd0) w = w | 32'h0000_1234;
            ref_decode(w, rs, rk, re, rm, rf, rsc);
            do_decode(w, 1'b0, lat);
            expect_result($sformatf("rnd%0d_%h", t, w), lat, rsc + 3, rs, rk, re, rm, rf,
                          1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
